// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_ADDR_W / REG_DATA_W : default register address / data widths
//   arb_state_t             : arbiter FSM states (IDLE, WAIT, FORCE)
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the pipeline (WB stage, MDU, decode reads) and the
// write-port arbiter.
//   slave  : arbiter side (consumes requests, drives rf_* and status)
//   master : pipeline side
//   wb_*           WB write request and the registered block back-pressure
//   mdu_issue*     MDU issue marking a destination pending
//   mdu_valid/ready/addr/data  MDU result handshake
//   rd_addr_a/b    decode read addresses, hazard_stall back
//   rf_*           registered write port into general_register
//   busy, proto_err  status
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) ();

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_block;
  logic              mdu_issue;
  logic [ADDR_W-1:0] mdu_issue_addr;
  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0] mdu_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              hazard_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;
  logic              proto_err;

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  mdu_issue, mdu_issue_addr,
    input  mdu_valid, mdu_addr, mdu_data,
    input  rd_addr_a, rd_addr_b,
    output wb_block, mdu_ready, hazard_stall,
    output rf_we, rf_waddr, rf_wdata,
    output busy, proto_err
  );

  modport master (
    output wb_we, wb_addr, wb_data,
    output mdu_issue, mdu_issue_addr,
    output mdu_valid, mdu_addr, mdu_data,
    output rd_addr_a, rd_addr_b,
    input  wb_block, mdu_ready, hazard_stall,
    input  rf_we, rf_waddr, rf_wdata,
    input  busy, proto_err
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_result_fifo.sv
// Synchronous FIFO holding MDU results ({addr, data}) until they win the
// register-file write port.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push, din  : write when push & !full
//   pop, dout  : dout is the head entry; pop advances when !empty
//   full, empty, level : occupancy status
module wb_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PTR_W] != rptr[PTR_W]) &&
                   (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign level   = wptr - rptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owner of the single general_register write port. Shares it between the
// WB stage and out-of-band MDU results (buffered in a small FIFO), keeps a
// pending-destination scoreboard for decode hazards, and forces a one-cycle
// WB block when a FIFO head has lost the port STARVE_MAX times in a row.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_wb_arbiter_if.slave (WB, MDU, decode reads, rf_* out)
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DATA_W     = REG_DATA_W,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int LVL_W = $clog2(QDEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  arb_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [ENT_W-1:0]  fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic              push;
  logic              wb_block;
  logic              wb_win;
  logic              head_win;
  logic              fifo_last;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              rf_mdu_q;
  logic              proto_err_q;

  logic [NREG-1:0]   pending, pending_n;

  // Results for r0 are acknowledged but never buffered.
  assign push      = bus.mdu_valid & ~fifo_full & (bus.mdu_addr != '0);
  assign wb_block  = (state == ARB_FORCE);
  assign wb_win    = ~wb_block & bus.wb_we & (bus.wb_addr != '0);
  assign head_win  = ~wb_win & ~fifo_empty;
  // The pop this cycle drains the last entry and nothing refills it.
  assign fifo_last = head_win & ~push & (fifo_level == LVL_W'(1));

  assign {head_addr, head_data} = fifo_head;

  wb_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (head_win),
    .din   ({bus.mdu_addr, bus.mdu_data}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ARB_IDLE: begin
        cnt_n = '0;
        if (push) state_n = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (head_win) begin
          cnt_n = '0;
          if (fifo_last) state_n = ARB_IDLE;
        end else if (!fifo_empty) begin
          // Head lost to WB; the STARVE_MAX-th loss arms the block.
          if (cnt == CNT_W'(STARVE_MAX - 1)) begin
            state_n = ARB_FORCE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (!push) begin
          state_n = ARB_IDLE;
        end
      end
      ARB_FORCE: begin
        cnt_n   = '0;
        state_n = fifo_last ? ARB_IDLE : ARB_WAIT;
      end
      default: begin
        state_n = ARB_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      rf_mdu_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      rf_we_q  <= wb_win | head_win;
      rf_mdu_q <= head_win;
      if (wb_win) begin
        rf_waddr_q <= bus.wb_addr;
        rf_wdata_q <= bus.wb_data;
      end else if (head_win) begin
        rf_waddr_q <= head_addr;
        rf_wdata_q <= head_data;
      end
      if (wb_block & bus.wb_we) proto_err_q <= 1'b1;
    end
  end

  // Clear lands after the MDU value is on rf_*; a same-cycle issue re-sets it.
  always_comb begin
    pending_n = pending;
    if (rf_we_q & rf_mdu_q) pending_n[rf_waddr_q] = 1'b0;
    if (bus.mdu_issue) pending_n[bus.mdu_issue_addr] = 1'b1;
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_n;
  end

  assign bus.wb_block     = wb_block;
  assign bus.mdu_ready    = ~fifo_full;
  assign bus.hazard_stall = pending[bus.rd_addr_a] | pending[bus.rd_addr_b];
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.busy         = ~fifo_empty | (|pending);
  assign bus.proto_err    = proto_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int QDEPTH     = 2;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wb_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .QDEPTH     (QDEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_we          = 1'b0;
    bus.wb_addr        = '0;
    bus.wb_data        = '0;
    bus.mdu_issue      = 1'b0;
    bus.mdu_issue_addr = '0;
    bus.mdu_valid      = 1'b0;
    bus.mdu_addr       = '0;
    bus.mdu_data       = '0;
    bus.rd_addr_a      = '0;
    bus.rd_addr_b      = '0;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.wb_we   = we;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.mdu_valid = v;
    bus.mdu_addr  = a;
    bus.mdu_data  = d;
  endtask

  // Push one MDU result alongside a WB write (empty FIFO: WB wins), then let
  // WB win STARVE_MAX more cycles. Ends in the cycle where wb_block must be 1.
  task automatic starve(input logic [4:0] ma, input logic [31:0] md, input logic [31:0] base);
    mdu(1'b1, ma, md);
    wb(1'b1, 5'd4, base);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    chk("starve_first_wb", bus.rf_wdata, base);
    for (int i = 1; i <= STARVE_MAX; i++) begin
      chk("starve_no_block", bus.wb_block, 1'b0);
      wb(1'b1, 5'd4, base + i);
      tick();
      chk("starve_wb_wins", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd4, base + i});
    end
    chk("starve_block_on", bus.wb_block, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.wb_we          = 1'($urandom);
      bus.wb_addr        = 5'($urandom);
      bus.wb_data        = $urandom;
      bus.mdu_issue      = 1'($urandom);
      bus.mdu_issue_addr = 5'($urandom);
      bus.mdu_valid      = 1'($urandom);
      bus.mdu_addr       = 5'($urandom);
      bus.mdu_data       = $urandom;
      bus.rd_addr_a      = 5'($urandom);
      bus.rd_addr_b      = 5'($urandom);
      tick();
    end
    chk("rst_rf_we", bus.rf_we, 1'b0);
    chk("rst_rf_waddr", bus.rf_waddr, 5'd0);
    chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
    chk("rst_wb_block", bus.wb_block, 1'b0);
    chk("rst_mdu_ready", bus.mdu_ready, 1'b1);
    chk("rst_hazard", bus.hazard_stall, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_proto_err", bus.proto_err, 1'b0);
    idle_inputs();
    #2;
    rst_n = 1'b1;
    tick();

    // WB-only write, latency one cycle; r0 write suppressed.
    wb(1'b1, 5'd3, 32'h1234);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("wb_write", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd3, 32'h1234});
    wb(1'b1, 5'd0, 32'h55);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("wb_r0", bus.rf_we, 1'b0);

    // MDU path with hazard.
    bus.mdu_issue      = 1'b1;
    bus.mdu_issue_addr = 5'd7;
    tick();
    bus.mdu_issue = 1'b0;
    bus.rd_addr_a = 5'd7;
    #1;
    chk("mdu_hazard_set", bus.hazard_stall, 1'b1);
    chk("mdu_busy", bus.busy, 1'b1);
    mdu(1'b1, 5'd7, 32'hCAFE);
    #1;
    chk("mdu_ready_empty", bus.mdu_ready, 1'b1);
    tick();                                     // edge N: push
    mdu(1'b0, 5'd0, 32'h0);
    chk("mdu_no_bypass", bus.rf_we, 1'b0);      // cycle N+1
    tick();
    chk("mdu_write", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd7, 32'hCAFE});
    chk("mdu_hazard_n2", bus.hazard_stall, 1'b1);
    tick();
    chk("mdu_hazard_n3", bus.hazard_stall, 1'b0);
    chk("mdu_busy_clr", bus.busy, 1'b0);
    bus.rd_addr_a = 5'd0;

    // Contention, bench honours the block.
    starve(5'd9, 32'hBEEF, 32'h100);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("force_mdu_write", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd9, 32'hBEEF});
    chk("force_block_off", bus.wb_block, 1'b0);
    chk("force_proto_ok", bus.proto_err, 1'b0);
    tick();
    chk("force_idle_after", bus.rf_we, 1'b0);

    // Fill to full, then drain in order across the pointer wrap.
    mdu(1'b1, 5'd10, 32'hA1);
    wb(1'b1, 5'd5, 32'h501);
    tick();
    mdu(1'b1, 5'd11, 32'hA2);
    wb(1'b1, 5'd5, 32'h502);
    #1;
    chk("fill_ready_one", bus.mdu_ready, 1'b1);
    tick();
    mdu(1'b1, 5'd12, 32'hA3);
    wb(1'b1, 5'd5, 32'h503);
    #1;
    chk("fill_ready_full", bus.mdu_ready, 1'b0);
    tick();
    wb(1'b0, 5'd0, 32'h0);                      // pop while full: ready stays low
    #1;
    chk("fill_ready_popcyc", bus.mdu_ready, 1'b0);
    chk("fill_wb_last", bus.rf_wdata, 32'h503);
    tick();
    chk("drain_1", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd10, 32'hA1});
    chk("fill_ready_again", bus.mdu_ready, 1'b1); // A3 accepted now
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    chk("drain_2", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd11, 32'hA2});
    tick();
    chk("drain_3_wrap", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd12, 32'hA3});
    tick();
    chk("drain_done", bus.rf_we, 1'b0);

    // Contention, bench violates the block.
    starve(5'd13, 32'hD0D0, 32'h200);
    wb(1'b1, 5'd6, 32'h6666);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("viol_mdu_write", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd13, 32'hD0D0});
    chk("viol_proto_err", bus.proto_err, 1'b1);
    tick();
    chk("viol_wb_absent", bus.rf_we, 1'b0);
    chk("viol_proto_sticky", bus.proto_err, 1'b1);

    // Reset mid-drain: FIFO full, two pending bits, rf_we=1.
    bus.mdu_issue      = 1'b1;
    bus.mdu_issue_addr = 5'd20;
    wb(1'b1, 5'd2, 32'h21);
    tick();
    bus.mdu_issue_addr = 5'd21;
    mdu(1'b1, 5'd20, 32'h2020);
    wb(1'b1, 5'd2, 32'h22);
    tick();
    bus.mdu_issue = 1'b0;
    mdu(1'b1, 5'd21, 32'h2121);
    wb(1'b1, 5'd2, 32'h23);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    wb(1'b1, 5'd2, 32'h24);
    bus.rd_addr_a = 5'd20;
    bus.rd_addr_b = 5'd21;
    #1;
    chk("pre_rst_hazard", bus.hazard_stall, 1'b1);
    chk("pre_rst_full", bus.mdu_ready, 1'b0);
    chk("pre_rst_rf_we", bus.rf_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rf_we", bus.rf_we, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_hazard", bus.hazard_stall, 1'b0);
    chk("mid_rst_ready", bus.mdu_ready, 1'b1);
    chk("mid_rst_proto", bus.proto_err, 1'b0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_no_write", bus.rf_we, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
